// File: rtl/adder_share_ctrl.sv
// Round-robin controller time-sharing one external combinational adder between N_REQ requesters.
// Optional saturating overflow counter built only with ADDER_SHARE_CTRL_OVF_CNT_EN defined.
module adder_share_ctrl #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*W-1:0]   req_a,
  input  logic [N_REQ*W-1:0]   req_b,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  input  logic [W:0]           add_sum,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [W:0]           rsp_sum,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          ovf_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [W-1:0]     r_add_a;
  logic [W-1:0]     r_add_b;
  logic             r_rsp_valid;
  logic [W:0]       r_rsp_sum;
  logic [IDW-1:0]   r_rsp_id;

  logic             w_found;
  logic [IDW-1:0]   w_grant;
  logic [W-1:0]     w_sel_a;
  logic [W-1:0]     w_sel_b;
  logic [N_REQ-1:0] w_ready;
  logic [IDW-1:0]   w_ptr_nxt;
  int               w_j;

  // First valid requester at or above r_ptr, wrapping past N_REQ-1.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_sel_a = '0;
    w_sel_b = '0;
    w_j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = int'(r_ptr) + k;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      if (!w_found && req_valid[w_j]) begin
        w_found = 1'b1;
        w_grant = IDW'(w_j);
        w_sel_a = req_a[w_j*W +: W];
        w_sel_b = req_b[w_j*W +: W];
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (rst_n && (r_state == ST_IDLE) && w_found) w_ready[w_grant] = 1'b1;
  end

  assign w_ptr_nxt = (r_id == IDW'(N_REQ - 1)) ? '0 : r_id + IDW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_id    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_add_a <= w_sel_a;
            r_add_b <= w_sel_b;
            r_id    <= w_grant;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_rsp_sum   <= add_sum;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= w_ptr_nxt;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ADDER_SHARE_CTRL_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_cnt <= 16'h0000;
    end else if ((r_state == ST_RESP) && rsp_ready && r_rsp_sum[W] &&
                 (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`else
  assign ovf_cnt = 16'h0000;
`endif

  assign req_ready = w_ready;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl with the shared adder modelled alongside the DUT.
module tb_adder_share_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic [8:0]  add_sum;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [8:0]  rsp_sum;
  logic [1:0]  rsp_id;
  logic [15:0] ovf_cnt;

  int n_checks;
  int n_errors;
  int exp_ovf;
  int ovf_en;

  logic [8:0] exp_sum [4];

  adder_share_ctrl #(.N_REQ(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .ovf_cnt   (ovf_cnt)
  );

  assign add_sum = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic chk_ovf(input string tag);
    chk(tag, 32'(ovf_cnt), 32'(ovf_en != 0 ? exp_ovf : 0));
  endtask

  initial begin
    logic [7:0] hold_sum;
    n_checks  = 0;
    n_errors  = 0;
    exp_ovf   = 0;
`ifdef ADDER_SHARE_CTRL_OVF_CNT_EN
    ovf_en = 1;
`else
    ovf_en = 0;
`endif
    exp_sum[0] = 9'h00F;
    exp_sum[1] = 9'h077;
    exp_sum[2] = 9'h100;
    exp_sum[3] = 9'h030;

    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_add_a", 32'(add_a), 32'h0);
    chk("rst_add_b", 32'(add_b), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk_ovf("rst_ovf_cnt");
    req_valid = 4'h0;
    rst_n     = 1'b1;
    tick();
    chk("idle_no_req", 32'(req_ready), 32'h0);

    set_op(0, 8'h0A, 8'h05);
    set_op(1, 8'h33, 8'h44);
    set_op(2, 8'hFF, 8'h01);
    set_op(3, 8'h10, 8'h20);

    // single request, no overflow
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    chk("t1_calc_ready", 32'(req_ready), 32'h0);
    chk("t1_add_a", 32'(add_a), 32'h0A);
    chk("t1_add_b", 32'(add_b), 32'h05);
    chk("t1_calc_valid", 32'(rsp_valid), 32'h0);
    tick();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_sum", 32'(rsp_sum), 32'h00F);
    chk("t1_rsp_id", 32'(rsp_id), 32'h0);
    tick();
    chk("t1_rsp_done", 32'(rsp_valid), 32'h0);

    // overflow from requester 2
    req_valid = 4'b0100;
    #1;
    chk("t2_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("t2_rsp_sum", 32'(rsp_sum), 32'h100);
    chk("t2_rsp_id", 32'(rsp_id), 32'h2);
    tick();
    exp_ovf++;
    chk_ovf("t2_ovf_cnt");

    // requester 3, then wrap-around with 0 and 3 valid
    req_valid = 4'b1000;
    #1;
    chk("t6_ready3", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("t6_rsp_sum3", 32'(rsp_sum), 32'h030);
    chk("t6_rsp_id3", 32'(rsp_id), 32'h3);
    tick();
    req_valid = 4'b1001;
    #1;
    chk("t6_wrap_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("t6_wrap_id", 32'(rsp_id), 32'h0);
    tick();

    // reset while in CALC; ptr was 1, must return to 0
    req_valid = 4'b0010;
    #1;
    chk("t5_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("t5_add_a", 32'(add_a), 32'h0);
    chk("t5_add_b", 32'(add_b), 32'h0);
    chk("t5_rsp_sum", 32'(rsp_sum), 32'h0);
    chk("t5_rsp_id", 32'(rsp_id), 32'h0);
    exp_ovf = 0;
    chk_ovf("t5_ovf_cnt");
    tick();
    tick();
    chk("t5_no_pulse", 32'(rsp_valid), 32'h0);

    // round-robin with all requesters valid
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t3_grant%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("t3_calc_ready%0d", k), 32'(req_ready), 32'h0);
      tick();
      chk($sformatf("t3_resp_ready%0d", k), 32'(req_ready), 32'h0);
      chk($sformatf("t3_rsp_valid%0d", k), 32'(rsp_valid), 32'h1);
      chk($sformatf("t3_rsp_sum%0d", k), 32'(rsp_sum), 32'(exp_sum[k % 4]));
      chk($sformatf("t3_rsp_id%0d", k), 32'(rsp_id), 32'(k % 4));
      tick();
      if (exp_sum[k % 4][8]) exp_ovf++;
    end
    chk_ovf("t3_ovf_cnt");

    // backpressure: ptr is 1, only requester 1 valid
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    chk("t4_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'hF;
    tick();
    hold_sum = rsp_sum[7:0];
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t4_valid%0d", c), 32'(rsp_valid), 32'h1);
      chk($sformatf("t4_sum%0d", c), 32'(rsp_sum), 32'h077);
      chk($sformatf("t4_id%0d", c), 32'(rsp_id), 32'h1);
      chk($sformatf("t4_ready%0d", c), 32'(req_ready), 32'h0);
      tick();
    end
    chk("t4_sum_low", 32'(hold_sum), 32'h77);
    chk("t4_still_valid", 32'(rsp_valid), 32'h1);
    rsp_ready = 1'b1;
    tick();
    chk("t4_delivered", 32'(rsp_valid), 32'h0);
    chk("t4_next_grant", 32'(req_ready), 32'h4);
    req_valid = 4'h0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
